// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin request/grant arbiter with a bounded tenure per owner.
// A tenure ends when the owner drops its request or after MAX_HOLD granted cycles.
module rr_req_gnt_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 hold_timeout
);

  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IdW-1:0]  gnt_id_q, gnt_id_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic            hold_timeout_q, hold_timeout_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  logic           win_found;
  logic [IdW-1:0] win_id;
  logic [IdW-1:0] cand;
  logic [IdW-1:0] next_ptr;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdW'((32'(ptr_q) + i) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign next_ptr = (gnt_id_q == IdW'(N - 1)) ? '0 : gnt_id_q + IdW'(1);

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    gnt_id_d       = gnt_id_q;
    ptr_d          = ptr_q;
    busy_d         = busy_q;
    hold_timeout_d = 1'b0;
    hold_cnt_d     = hold_cnt_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StGrant;
          gnt_d      = N'(1) << win_id;
          gnt_id_d   = win_id;
          busy_d     = 1'b1;
          hold_cnt_d = CntW'(1);
        end
      end
      StGrant: begin
        if (!req[gnt_id_q] || (hold_cnt_q == CntW'(MAX_HOLD))) begin
          // Tenure ends; a forced end passes through RELEASE for one cycle.
          state_d        = req[gnt_id_q] ? StRelease : StIdle;
          hold_timeout_d = req[gnt_id_q];
          gnt_d          = '0;
          gnt_id_d       = '0;
          busy_d         = 1'b0;
          hold_cnt_d     = '0;
          ptr_d          = next_ptr;
        end else begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      gnt_q          <= '0;
      gnt_id_q       <= '0;
      ptr_q          <= '0;
      busy_q         <= 1'b0;
      hold_timeout_q <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      gnt_id_q       <= gnt_id_d;
      ptr_q          <= ptr_d;
      busy_q         <= busy_d;
      hold_timeout_q <= hold_timeout_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_id       = gnt_id_q;
  assign busy         = busy_q;
  assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Bench for rr_req_gnt_arbiter: cycle model feeding a scoreboard, directed scenarios,
// and per-cycle property checks on latency, one-hot, handoff gap and starvation.
module tb_rr_req_gnt_arbiter;

  localparam int N     = 4;
  localparam int MH    = 8;
  localparam int BOUND = N * (MH + 2);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         hold_timeout;

  rr_req_gnt_arbiter #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .gnt          (gnt),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         busy;
    logic         to;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: 0 idle, 1 grant, 2 release
  int m_state = 0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rst);
    bit found;
    if (rst) begin
      m_state = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_state == 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && r[(m_ptr + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_state = 1;
        m_cnt   = 1;
      end
    end else if (m_state == 1) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_state = 0;
      end else if (m_cnt == MH) begin
        m_ptr   = (m_owner + 1) % N;
        m_state = 2;
        m_to    = 1'b1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_state = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rst);
    exp_t e;
    req   = r;
    reset = rst;
    model_edge(r, rst);
    e.gnt  = (m_state == 1) ? N'(1) << m_owner : '0;
    e.id   = (m_state == 1) ? 2'(m_owner) : 2'd0;
    e.busy = (m_state == 1);
    e.to   = m_to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(0), 32'(1));
    end else begin
      e = sb_q.pop_front();
      check_val("sb_gnt",  32'(gnt),          32'(e.gnt));
      check_val("sb_id",   32'(gnt_id),       32'(e.id));
      check_val("sb_busy", 32'(busy),         32'(e.busy));
      check_val("sb_to",   32'(hold_timeout), 32'(e.to));
    end
  endtask

  // Per-cycle properties, sampled mid-cycle and skipped around reset
  logic [N-1:0] prev_req  = '0;
  logic [N-1:0] prev_gnt  = '0;
  logic         prev_rst  = 1'b1;
  logic         prev_idle = 1'b0;
  int           waits[N];
  int           exp_id;

  always @(negedge clk) begin
    if (reset || prev_rst) begin
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      check_val("p_onehot", 32'($onehot0(gnt)), 32'(1));
      exp_id = 0;
      for (int i = 0; i < N; i++) if (gnt[i]) exp_id = i;
      check_val("p_id_match", 32'(gnt_id), 32'(exp_id));
      if (prev_idle && prev_req != '0)
        check_val("p_latency", 32'((gnt & prev_req) != '0), 32'(1));
      if (prev_gnt != '0 && gnt != '0)
        check_val("p_no_handoff", 32'(gnt), 32'(prev_gnt));
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt[i]) waits[i]++;
        else waits[i] = 0;
        check_val("p_starve", 32'(waits[i] <= BOUND), 32'(1));
      end
    end
    prev_rst  = reset;
    prev_req  = req;
    prev_gnt  = gnt;
    prev_idle = (gnt == '0) && !hold_timeout;
  end

  int           n_to;
  int           n_first;
  logic [N-1:0] first_gnt[5];
  logic [N-1:0] exp_first[5];
  logic [N-1:0] last_gnt;
  logic [N-1:0] r_rand;

  initial begin
    exp_first[0] = 4'b0001; exp_first[1] = 4'b0010; exp_first[2] = 4'b0100;
    exp_first[3] = 4'b1000; exp_first[4] = 4'b0001;

    // Reset, then a single requester for three cycles
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check_val("rst_gnt",  32'(gnt),          32'(0));
    check_val("rst_busy", 32'(busy),         32'(0));
    check_val("rst_to",   32'(hold_timeout), 32'(0));
    step(4'b0001, 1'b0);
    check_val("r28_lat", 32'(gnt), 32'h1);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    check_val("r28_third", 32'(gnt), 32'h1);
    step(4'b0000, 1'b0);
    check_val("r28_drop", 32'(gnt), 32'h0);
    step(4'b0000, 1'b0);
    step(4'b1111, 1'b0);
    check_val("r28_ptr1", 32'(gnt), 32'h2);

    // All requesters held: rotation with forced release
    step(4'b0000, 1'b1);
    n_to = 0; n_first = 0; last_gnt = '0;
    for (int c = 0; c < 50; c++) begin
      step(4'b1111, 1'b0);
      if (hold_timeout) n_to++;
      if (gnt != '0 && last_gnt == '0 && n_first < 5) begin
        first_gnt[n_first] = gnt;
        n_first++;
      end
      last_gnt = gnt;
    end
    check_val("r29_timeouts", 32'(n_to), 32'(5));
    check_val("r29_tenures", 32'(n_first), 32'(5));
    for (int i = 0; i < 5; i++) check_val("r29_order", 32'(first_gnt[i]), 32'(exp_first[i]));
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // ptr=1 with requesters 0 and 2
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0101, 1'b0);
    check_val("r30_first", 32'(gnt), 32'h4);
    step(4'b0101, 1'b0);
    step(4'b0001, 1'b0);
    check_val("r30_gap", 32'(gnt), 32'h0);
    step(4'b0001, 1'b0);
    check_val("r30_next", 32'(gnt), 32'h1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Non-owner toggling during a tenure
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step((c % 2 == 0) ? 4'b1010 : 4'b0010, 1'b0);
      check_val("r31_hold", 32'(gnt), 32'h2);
    end
    step(4'b1000, 1'b0);
    check_val("r31_gap", 32'(gnt), 32'h0);
    step(4'b1000, 1'b0);
    check_val("r31_next", 32'(gnt), 32'h8);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Reset mid-tenure
    step(4'b0000, 1'b1);
    for (int c = 0; c < 5; c++) step(4'b0010, 1'b0);
    check_val("r32_busy", 32'(busy), 32'(1));
    step(4'b0010, 1'b1);
    check_val("r32_rst_gnt",  32'(gnt),    32'h0);
    check_val("r32_rst_busy", 32'(busy),   32'(0));
    check_val("r32_rst_id",   32'(gnt_id), 32'(0));
    step(4'b0010, 1'b0);
    check_val("r32_regrant", 32'(gnt), 32'h2);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Random sticky requests with rare resets
    r_rand = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) r_rand[b] = ~r_rand[b];
      step(r_rand, ($urandom_range(0, 99) == 0));
    end
    step(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_req_gnt_arbiter.md
RR_REQ_GNT_ARBITER -- requirements
Module: rr_req_gnt_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 8, max consecutive granted cycles per tenure (2..255).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  N  request vector; bit i held high by requester i while it wants the resource.
REQ-006 gnt  output  N  registered grant vector, one-hot or zero.
REQ-007 gnt_id  output  clog2(N)  registered index of current owner; 0 when gnt is zero.
REQ-008 busy  output  1  registered; high while in GRANT.
REQ-009 hold_timeout  output  1  registered one-cycle pulse when a tenure is forcibly ended.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-011 IDLE, req nonzero: pick first set bit scanning ptr, ptr+1, ... mod N; next edge load gnt one-hot, gnt_id, busy=1, hold_cnt=1, go GRANT.
REQ-012 IDLE, req zero: stay IDLE, gnt=0.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled at edge k yields gnt at edge k+1 (req |=> gnt).
REQ-014 GRANT, req[gnt_id]=1 and hold_cnt<MAX_HOLD: stay GRANT, hold_cnt+1, gnt unchanged.
REQ-015 GRANT, req[gnt_id]=0: next edge gnt=0, busy=0, ptr=(gnt_id+1) mod N, go IDLE.
REQ-016 GRANT, req[gnt_id]=1 and hold_cnt==MAX_HOLD: next edge gnt=0, busy=0, hold_timeout=1, ptr=(gnt_id+1) mod N, go RELEASE.
REQ-017 RELEASE lasts exactly one cycle, gnt=0, then IDLE; hold_timeout returns to 0.
REQ-018 Between two tenures gnt SHALL be zero for at least one cycle; no back-to-back grant handoff.
REQ-019 Changes on req bits other than req[gnt_id] SHALL NOT affect gnt while in GRANT.
REQ-020 ptr wraps from N-1 to 0; ptr changes only on tenure end (REQ-015, REQ-016).
REQ-021 hold_cnt is clog2(MAX_HOLD+1) bits and SHALL never exceed MAX_HOLD.
REQ-022 Simultaneous requests in IDLE: only the round-robin winner is granted; losers keep waiting.
REQ-023 Any requester with req continuously high SHALL be granted within N*(MAX_HOLD+2) cycles.
REQ-024 gnt SHALL never have more than one bit set; gnt_id SHALL always match the set bit.

Reset
REQ-025 reset high at an edge: state=IDLE, gnt=0, gnt_id=0, busy=0, hold_timeout=0, hold_cnt=0, ptr=0.
REQ-026 reset SHALL override all transitions, including mid-GRANT and RELEASE; outputs zero at the edge following reset assertion.
REQ-027 Request checking is disabled while reset is high; first grant possible at the edge after the first cycle with reset low and req nonzero.

Verification
REQ-028 N=4, MAX_HOLD=8: reset, then req=0001 for 3 cycles then 0000 -> gnt=0001 for 3 cycles starting one cycle after req, then 0000, ptr=1.
REQ-029 req=1111 held from IDLE, ptr=0 -> grants 0001, 0010, 0100, 1000, 0001 in order, each 8 cycles, hold_timeout pulse and one RELEASE zero cycle plus one IDLE zero cycle between each.
REQ-030 req=0101 with ptr=1 -> gnt=0100 first; after req[2] drops -> one zero cycle, then gnt=0001.
REQ-031 Owner 1 granted, req[3] toggles during tenure -> gnt stays 0010; after release gnt=1000.
REQ-032 reset asserted at hold_cnt=5 in GRANT -> next edge all outputs 0, ptr=0; after reset low with req=0010 -> gnt=0010 one cycle later.
REQ-033 Bench SHALL carry concurrent checks for REQ-013, REQ-018, REQ-024 and REQ-023, disabled during reset, failing with $display of $time.
